// File: rtl/teclado_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : teclado_pkg
// Function : Shared types and constants for the ATM keypad front-end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package teclado_pkg;

  typedef enum logic [1:0] {
    ESCANEO        = 2'd0,
    REBOTE         = 2'd1,
    EMITIR         = 2'd2,
    ESPERA_LIBERAR = 2'd3
  } estado_t;

  typedef struct packed {
    logic       es_digito;
    logic [3:0] valor;
  } tecla_t;

  localparam logic [2:0] c_esp_a   = 3'd0;
  localparam logic [2:0] c_esp_b   = 3'd1;
  localparam logic [2:0] c_esp_c   = 3'd2;
  localparam logic [2:0] c_esp_d   = 3'd3;
  localparam logic [2:0] c_esp_ast = 3'd4;
  localparam logic [2:0] c_esp_alm = 3'd5;

  localparam logic [3:0] c_col_reposo = 4'b1111;

  // Indexed by {row, col}; function keys carry their 3-bit code in valor.
  localparam tecla_t c_mapa_teclas [16] = '{
    '{1'b1, 4'd1}, '{1'b1, 4'd2}, '{1'b1, 4'd3}, '{1'b0, 4'(c_esp_a)},
    '{1'b1, 4'd4}, '{1'b1, 4'd5}, '{1'b1, 4'd6}, '{1'b0, 4'(c_esp_b)},
    '{1'b1, 4'd7}, '{1'b1, 4'd8}, '{1'b1, 4'd9}, '{1'b0, 4'(c_esp_c)},
    '{1'b0, 4'(c_esp_ast)}, '{1'b1, 4'd0}, '{1'b0, 4'(c_esp_alm)}, '{1'b0, 4'(c_esp_d)}
  };

  function automatic logic un_solo_bajo(input logic [3:0] patron);
    return ($countones(~patron) == 1);
  endfunction

  function automatic logic [1:0] indice_col(input logic [3:0] patron);
    logic [1:0] idx;
    idx = 2'd0;
    case (patron)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teclado_sincronizador.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : teclado_sincronizador
// Function : Two-flop synchroniser, asynchronously reset to all-ones (idle).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module teclado_sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/teclado_atm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : teclado_atm
// Function : 4x4 keypad scanner/debouncer, one strobe per accepted key press.
// Options  : TECLADO_BLOQUEO_EN adds input bloqueo, which suppresses strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module teclado_atm
  import teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] filas,
  input  logic [3:0] columnas,
`ifdef TECLADO_BLOQUEO_EN
  input  logic       bloqueo,
`endif
  output logic       digito_stb,
  output logic [3:0] digito,
  output logic       especial_stb,
  output logic [2:0] especial
);

  localparam int c_cnt_max = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_fin_escaneo = c_cnt_w'(SCAN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_fin_rebote  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  if (SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 2) begin : g_param_invalido
    $error("teclado_atm: SCAN_CYCLES must be >= 3 and DEBOUNCE_CYCLES >= 2");
  end

  estado_t            r_estado,       w_estado_sig;
  logic [1:0]         r_fila,         w_fila_sig;
  logic [c_cnt_w-1:0] r_cnt,          w_cnt_sig;
  logic [3:0]         r_patron,       w_patron_sig;
  logic [1:0]         r_col,          w_col_sig;
  logic [3:0]         r_digito,       w_digito_sig;
  logic [2:0]         r_especial,     w_especial_sig;
  logic               r_digito_stb,   w_digito_stb_sig;
  logic               r_especial_stb, w_especial_stb_sig;
  logic [3:0]         w_col_s;
  logic               w_bloqueo;
  tecla_t             w_tecla;

`ifdef TECLADO_BLOQUEO_EN
  assign w_bloqueo = bloqueo;
`else
  assign w_bloqueo = 1'b0;
`endif

  teclado_sincronizador #(
    .WIDTH (4)
  ) u_sincronizador (
    .clk   (clk),
    .reset (reset),
    .d     (columnas),
    .q     (w_col_s)
  );

  assign w_tecla = c_mapa_teclas[{r_fila, r_col}];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado       <= ESCANEO;
      r_fila         <= 2'd0;
      r_cnt          <= '0;
      r_patron       <= c_col_reposo;
      r_col          <= 2'd0;
      r_digito       <= 4'd0;
      r_especial     <= 3'd0;
      r_digito_stb   <= 1'b0;
      r_especial_stb <= 1'b0;
    end else begin
      r_estado       <= w_estado_sig;
      r_fila         <= w_fila_sig;
      r_cnt          <= w_cnt_sig;
      r_patron       <= w_patron_sig;
      r_col          <= w_col_sig;
      r_digito       <= w_digito_sig;
      r_especial     <= w_especial_sig;
      r_digito_stb   <= w_digito_stb_sig;
      r_especial_stb <= w_especial_stb_sig;
    end
  end

  always_comb begin
    w_estado_sig       = r_estado;
    w_fila_sig         = r_fila;
    w_cnt_sig          = r_cnt;
    w_patron_sig       = r_patron;
    w_col_sig          = r_col;
    w_digito_sig       = r_digito;
    w_especial_sig     = r_especial;
    w_digito_stb_sig   = 1'b0;
    w_especial_stb_sig = 1'b0;

    case (r_estado)
      ESCANEO: begin
        if (r_cnt == c_fin_escaneo) begin
          w_cnt_sig = '0;
          // Ghosting (two or more low columns) is treated like no press.
          if (un_solo_bajo(w_col_s)) begin
            w_patron_sig = w_col_s;
            w_col_sig    = indice_col(w_col_s);
            w_estado_sig = REBOTE;
          end else begin
            w_fila_sig = r_fila + 2'd1;
          end
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end

      REBOTE: begin
        if (w_col_s != r_patron) begin
          w_cnt_sig    = '0;
          w_estado_sig = ESCANEO;
        end else if (r_cnt == c_fin_rebote) begin
          w_cnt_sig    = '0;
          w_estado_sig = EMITIR;
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end

      EMITIR: begin
        w_cnt_sig    = '0;
        w_estado_sig = ESPERA_LIBERAR;
        if (!w_bloqueo) begin
          if (w_tecla.es_digito) begin
            w_digito_sig     = w_tecla.valor;
            w_digito_stb_sig = 1'b1;
          end else begin
            w_especial_sig     = 3'(w_tecla.valor);
            w_especial_stb_sig = 1'b1;
          end
        end
      end

      ESPERA_LIBERAR: begin
        if (w_col_s != c_col_reposo) begin
          w_cnt_sig = '0;
        end else if (r_cnt == c_fin_rebote) begin
          w_cnt_sig    = '0;
          w_fila_sig   = r_fila + 2'd1;
          w_estado_sig = ESCANEO;
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end

      default: begin
        w_cnt_sig    = '0;
        w_estado_sig = ESCANEO;
      end
    endcase
  end

  assign filas        = ~(4'b0001 << r_fila);
  assign digito_stb   = r_digito_stb;
  assign digito       = r_digito;
  assign especial_stb = r_especial_stb;
  assign especial     = r_especial;

endmodule
`default_nettype wire

// File: tb/tb_teclado_atm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_teclado_atm
// Function : Self-checking bench for teclado_atm with a behavioural keypad.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_teclado_atm;

  localparam int SCAN    = 4;
  localparam int DEB     = 16;
  localparam int LAT_MAX = 4 * SCAN + 2 + DEB + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic       digito_stb;
  logic [3:0] digito;
  logic       especial_stb;
  logic [2:0] especial;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_dig   = 0;
  int n_esp   = 0;
  int last_stb_cyc = 0;

  logic [15:0] pressed = '0;
  logic [3:0]  exp_dig = '0;
  logic [2:0]  exp_esp = '0;
  string       mapa    = "123A456B789C*0#D";

  teclado_atm #(
    .SCAN_CYCLES     (SCAN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .filas        (filas),
    .columnas     (columnas),
    .digito_stb   (digito_stb),
    .digito       (digito),
    .especial_stb (especial_stb),
    .especial     (especial)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    columnas = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!filas[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) columnas[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (digito_stb || especial_stb) begin
      check("stb_exclusivo", {31'd0, digito_stb & especial_stb}, 32'd0);
      last_stb_cyc = cyc;
      if (digito_stb)   n_dig++;
      if (especial_stb) n_esp++;
    end
  end

  task automatic modelo(input int idx, output bit es_dig, output int val);
    byte ch;
    ch = mapa[idx];
    es_dig = (ch >= "0" && ch <= "9");
    val = 0;
    if (es_dig) val = ch - "0";
    else case (ch)
      "A": val = 0;
      "B": val = 1;
      "C": val = 2;
      "D": val = 3;
      "*": val = 4;
      "#": val = 5;
      default: val = 7;
    endcase
  endtask

  task automatic press_key(input int idx, input int chatter, input int hold);
    bit es_dig;
    int val, d0, e0, c0, lat;
    modelo(idx, es_dig, val);
    d0 = n_dig;
    e0 = n_esp;
    @(posedge clk); #1;
    for (int i = 0; i < chatter; i++) begin
      pressed[idx] = ~pressed[idx];
      @(posedge clk); #1;
    end
    if (chatter > 0) check("chatter_quiet", n_dig + n_esp - d0 - e0, 0);
    pressed[idx] = 1'b1;
    c0  = cyc;
    lat = -1;
    for (int i = 0; i < LAT_MAX + 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (n_dig + n_esp != d0 + e0) lat = last_stb_cyc - c0;
    end
    if (lat < 0) check("strobe_timeout", 0, 1);
    else         check("latencia", {31'd0, lat <= LAT_MAX}, 1);
    repeat (hold) @(posedge clk);
    #1 pressed[idx] = 1'b0;
    repeat (DEB + 12) @(posedge clk);
    #1;
    if (es_dig) exp_dig = 4'(val);
    else        exp_esp = 3'(val);
    check("n_digito_stb",   n_dig - d0, es_dig ? 1 : 0);
    check("n_especial_stb", n_esp - e0, es_dig ? 0 : 1);
    check("digito",   {28'd0, digito},   {28'd0, exp_dig});
    check("especial", {29'd0, especial}, {29'd0, exp_esp});
  endtask

  initial begin
    logic [3:0]  prev;
    logic [15:0] pin;
    int          cambios, base;
    bit          found;

    #2;
    check("rst_filas",        {28'd0, filas},  32'hE);
    check("rst_digito",       {28'd0, digito}, 0);
    check("rst_digito_stb",   {31'd0, digito_stb}, 0);
    check("rst_especial",     {29'd0, especial}, 0);
    check("rst_especial_stb", {31'd0, especial_stb}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    press_key(5, 0, 200);      // '5'
    press_key(8, 6, 100);      // '7' with chatter
    press_key(14, 0, 60);      // '#'

    for (int i = 0; i < 10; i++)
      press_key($urandom_range(0, 15), ($urandom_range(0, 1) != 0) ? 6 : 0,
                $urandom_range(40, 200));

    // Two keys in row 0: no strobes, rows keep rotating.
    base = n_dig + n_esp;
    @(posedge clk); #1;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    prev = filas;
    cambios = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (filas != prev) begin
        check("filas_rot", {28'd0, filas}, {28'd0, prev[2:0], prev[3]});
        prev = filas;
        cambios++;
      end
    end
    check("filas_moving", {31'd0, cambios >= 100}, 1);
    check("ghost_quiet", n_dig + n_esp - base, 0);
    pressed = '0;
    repeat (DEB + 12) @(posedge clk);

    pin = '0;
    press_key(0, 0, 20); pin = {pin[11:0], digito};
    press_key(1, 0, 20); pin = {pin[11:0], digito};
    press_key(2, 0, 20); pin = {pin[11:0], digito};
    press_key(4, 0, 20); pin = {pin[11:0], digito};
    check("pin", {16'd0, pin}, 32'h1234);

    // Reset while '9' is being debounced.
    @(posedge clk); #1;
    pressed[10] = 1'b1;
    prev = filas;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (filas == 4'b1011 && prev != 4'b1011) found = 1'b1;
      prev = filas;
    end
    check("fila2_visto", {31'd0, found}, 1);
    repeat (SCAN + 4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rr_filas",        {28'd0, filas},  32'hE);
    check("rr_digito",       {28'd0, digito}, 0);
    check("rr_digito_stb",   {31'd0, digito_stb}, 0);
    check("rr_especial",     {29'd0, especial}, 0);
    check("rr_especial_stb", {31'd0, especial_stb}, 0);
    pressed[10] = 1'b0;
    base = n_dig + n_esp;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_dig = '0;
    exp_esp = '0;
    check("post_rst_filas", {28'd0, filas}, 32'hE);
    repeat (150) @(posedge clk);
    #1;
    check("post_rst_quiet", n_dig + n_esp - base, 0);
    press_key(10, 0, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
